spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank_pkg.sv | 16 +
 rtl/spi_edge_sync.sv | 38 +++
 rtl/spi_reg_bank.sv | 202 ++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank.
// FSM encoding and command-byte field constants.
package spi_reg_bank_pkg;

   localparam int CMD_RW_BIT = 7;
   localparam int ADDR_W     = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_COMMIT
   } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser with registered rise/fall pulses
// for one asynchronous input; pulses lag the input by 3 clocks.
module spi_edge_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic r_fall;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_sig;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
         r_fall <= ~r_sync & r_prev;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI slave register bank: writes land in a shadow copy and are
// committed to the live registers together when chip select rises.
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter bit SAMPLE_NEDGE = 1'b1,
   parameter bit AUTO_INC     = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  MCU_SCK_i,
   input  logic                  MCU_MOSI_i,
   input  logic                  MCU_NSS_i,
   output logic                  MCU_MISO_o,
   output logic [NUM_REGS*8-1:0] reg_q,
   output logic                  commit_o,
   output logic [NUM_REGS-1:0]   commit_mask_o
);

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_bitcnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [6:0]          r_rx;
   logic [7:0]          r_tx;
   logic [7:0]          r_shadow [NUM_REGS];
   logic [7:0]          r_regs   [NUM_REGS];
   logic [NUM_REGS-1:0] r_dirty;
   logic [NUM_REGS-1:0] r_mask;
   logic                r_commit;

   logic              w_sck_rise;
   logic              w_sck_fall;
   logic              w_nss_rise;
   logic              w_nss_fall;
   logic              w_smp;
   logic [7:0]        w_byte;
   logic              w_byte_done;
   logic [ADDR_W-1:0] w_load_addr;
   logic [7:0]        w_load_byte;

   spi_edge_sync #(.RST_VAL(1'b0)) u_sck_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .i_sig   (MCU_SCK_i),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   spi_edge_sync #(.RST_VAL(1'b1)) u_nss_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .i_sig   (MCU_NSS_i),
      .o_rise  (w_nss_rise),
      .o_fall  (w_nss_fall)
   );

   assign w_smp       = SAMPLE_NEDGE ? w_sck_fall : w_sck_rise;
   assign w_byte      = {r_rx, MCU_MOSI_i};
   assign w_byte_done = w_smp & (r_bitcnt == 3'd7);

   // Next tx byte: the command's address, or the following one in a read.
   always_comb begin
      w_load_byte = 8'h00;
      if (r_state == ST_CMD) begin
         w_load_addr = w_byte[ADDR_W-1:0];
      end else if (AUTO_INC) begin
         w_load_addr = r_addr + 7'd1;
      end else begin
         w_load_addr = r_addr;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_load_addr == ADDR_W'(i)) begin
            w_load_byte = r_regs[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_nss_fall) begin
               w_next = ST_CMD;
            end
         end
         ST_CMD: begin
            if (w_nss_rise) begin
               w_next = ST_IDLE;
            end else if (w_byte_done) begin
               w_next = w_byte[CMD_RW_BIT] ? ST_RD_DATA : ST_WR_DATA;
            end
         end
         ST_WR_DATA, ST_RD_DATA: begin
            if (w_nss_rise) begin
               w_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_next = w_nss_fall ? ST_CMD : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_bitcnt <= 3'd0;
         r_addr   <= '0;
         r_rx     <= '0;
         r_tx     <= 8'h00;
         r_dirty  <= '0;
         r_mask   <= '0;
         r_commit <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_shadow[i] <= 8'h00;
            r_regs[i]   <= 8'h00;
         end
      end else begin
         r_commit <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_nss_fall) begin
                  r_bitcnt <= 3'd0;
               end
            end
            ST_CMD: begin
               if (!w_nss_rise && w_smp) begin
                  r_rx     <= w_byte[6:0];
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (w_byte_done) begin
                     r_addr <= w_byte[ADDR_W-1:0];
                     r_tx   <= w_load_byte;
                  end
               end
            end
            ST_WR_DATA: begin
               if (!w_nss_rise && w_smp) begin
                  r_rx     <= w_byte[6:0];
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (w_byte_done) begin
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (r_addr == ADDR_W'(i)) begin
                           r_shadow[i] <= w_byte;
                           r_dirty[i]  <= 1'b1;
                        end
                     end
                     if (AUTO_INC) begin
                        r_addr <= r_addr + 7'd1;
                     end
                  end
               end
            end
            ST_RD_DATA: begin
               if (!w_nss_rise && w_smp) begin
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (w_byte_done) begin
                     r_tx <= w_load_byte;
                     if (AUTO_INC) begin
                        r_addr <= r_addr + 7'd1;
                     end
                  end else begin
                     r_tx <= {r_tx[6:0], 1'b0};
                  end
               end
            end
            ST_COMMIT: begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (r_dirty[i]) begin
                     r_regs[i] <= r_shadow[i];
                  end
               end
               r_mask   <= r_dirty;
               r_commit <= |r_dirty;
               r_dirty  <= '0;
               if (w_nss_fall) begin
                  r_bitcnt <= 3'd0;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
      assign reg_q[8*g +: 8] = r_regs[g];
   end

   assign MCU_MISO_o    = (r_state == ST_RD_DATA) & r_tx[7];
   assign commit_o      = r_commit;
   assign commit_mask_o = r_mask;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench: frame-level model predicts commits and read bytes,
// monitors compare them as the DUTs produce them.
`timescale 1ns/1ps
module tb_spi_reg_bank;

   localparam int N    = 32;
   localparam int HALF = 80;

   typedef struct packed {
      logic [N-1:0]   mask;
      logic [N*8-1:0] regs;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic phase = 1'b0;
   logic mosi = 1'b0;
   logic nss = 1'b1;
   logic sel = 1'b0;

   logic sck_a, nss_a, sck_b, nss_b;
   logic miso_a, miso_b;
   logic commit_a, commit_b;
   logic [N*8-1:0] regq_a, regq_b;
   logic [N-1:0] mask_a, mask_b;

   exp_t exp_a[$];
   exp_t exp_b[$];
   logic [7:0] rd_q[$];
   logic [7:0] live_a[N];
   logic [7:0] live_b[N];
   logic [7:0] dbuf[4];
   int errors = 0;
   int checks = 0;
   int frame_no = 0;

   always #5 clock = ~clock;

   assign sck_a = sel ? 1'b0 : phase;
   assign nss_a = sel ? 1'b1 : nss;
   assign sck_b = sel ? ~phase : 1'b1;
   assign nss_b = sel ? nss : 1'b1;

   spi_reg_bank #(.NUM_REGS(N), .SAMPLE_NEDGE(1'b1), .AUTO_INC(1'b1)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .MCU_SCK_i     (sck_a),
      .MCU_MOSI_i    (mosi),
      .MCU_NSS_i     (nss_a),
      .MCU_MISO_o    (miso_a),
      .reg_q         (regq_a),
      .commit_o      (commit_a),
      .commit_mask_o (mask_a)
   );

   spi_reg_bank #(.NUM_REGS(N), .SAMPLE_NEDGE(1'b0), .AUTO_INC(1'b0)) dut_b (
      .clock         (clock),
      .reset_n       (reset_n),
      .MCU_SCK_i     (sck_b),
      .MCU_MOSI_i    (mosi),
      .MCU_NSS_i     (nss_b),
      .MCU_MISO_o    (miso_b),
      .reg_q         (regq_b),
      .commit_o      (commit_b),
      .commit_mask_o (mask_b)
   );

   task automatic chk(input string name, input logic [N*8-1:0] act,
                      input logic [N*8-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   function automatic logic [N*8-1:0] flat(input logic [7:0] a[N]);
      logic [N*8-1:0] r;
      for (int i = 0; i < N; i++) r[8*i +: 8] = a[i];
      return r;
   endfunction

   task automatic send_bit(input logic b);
      phase = 1'b1;
      mosi  = b;
      #HALF;
      phase = 1'b0;
      #HALF;
   endtask

   // One chip-select frame: model prediction first, then the wire activity.
   task automatic frame(input bit s, input logic [7:0] cmd, input int n,
                        input int tail);
      logic [7:0] nxt[N];
      logic [N-1:0] m;
      exp_t e;
      int a;
      int inc;
      a   = int'(cmd[6:0]);
      inc = s ? 0 : 1;
      m   = '0;
      nxt = s ? live_b : live_a;
      for (int k = 0; k < n; k++) begin
         if (cmd[7]) begin
            rd_q.push_back(a < N ? live_a[a] : 8'h00);
         end else if (a < N) begin
            nxt[a] = dbuf[k];
            m[a]   = 1'b1;
         end
         a = (a + inc) % 128;
      end
      if (m != '0) begin
         e.mask = m;
         e.regs = flat(nxt);
         if (s) exp_b.push_back(e);
         else exp_a.push_back(e);
      end
      sel = s;
      nss = 1'b0;
      frame_no++;
      #(2*HALF);
      for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
      for (int k = 0; k < n; k++)
         for (int i = 7; i >= 0; i--) send_bit(dbuf[k][i]);
      for (int i = 0; i < tail; i++) send_bit(1'($urandom));
      #HALF;
      if (s) chk("pre_rise_b", regq_b, flat(live_b));
      else chk("pre_rise_a", regq_a, flat(live_a));
      nss = 1'b1;
      if (s) live_b = nxt;
      else live_a = nxt;
      #(4*HALF);
   endtask

   initial begin : commit_mon
      exp_t e;
      forever begin
         @(negedge clock);
         if (commit_a === 1'b1) begin
            if (exp_a.size() == 0) begin
               chk("unexpected_commit_a", {{(N*8-1){1'b0}}, commit_a}, '0);
            end else begin
               e = exp_a.pop_front();
               chk("commit_mask_a", mask_a, e.mask);
               chk("commit_regs_a", regq_a, e.regs);
            end
         end
         if (commit_b === 1'b1) begin
            if (exp_b.size() == 0) begin
               chk("unexpected_commit_b", {{(N*8-1){1'b0}}, commit_b}, '0);
            end else begin
               e = exp_b.pop_front();
               chk("commit_mask_b", mask_b, e.mask);
               chk("commit_regs_b", regq_b, e.regs);
            end
         end
      end
   end

   initial begin : miso_mon
      int last;
      int bn;
      int bi;
      logic [7:0] mo;
      logic [7:0] mi;
      bit rd;
      last = -1;
      bn = 0;
      bi = 0;
      mo = 8'h00;
      mi = 8'h00;
      rd = 1'b0;
      forever begin
         @(negedge phase);
         if (sel == 1'b0 && nss == 1'b0) begin
            if (frame_no != last) begin
               last = frame_no;
               bn = 0;
               bi = 0;
            end
            mo = {mo[6:0], mosi};
            mi = {mi[6:0], miso_a};
            bn++;
            if (bn == 8) begin
               bn = 0;
               if (bi == 0) begin
                  rd = mo[7];
                  chk("miso_during_cmd", {{(N*8-8){1'b0}}, mi}, '0);
               end else if (rd) begin
                  if (rd_q.size() == 0)
                     chk("extra_read_byte", {{(N*8-8){1'b0}}, mi}, '1);
                  else
                     chk("read_byte", {{(N*8-8){1'b0}}, mi},
                         {{(N*8-8){1'b0}}, rd_q.pop_front()});
               end
               bi++;
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         live_a[i] = 8'h00;
         live_b[i] = 8'h00;
      end
      #23;
      reset_n = 1'b1;
      #20;
      chk("reset_regs", regq_a, '0);
      chk("reset_mask", {{(N*8-N){1'b0}}, mask_a}, '0);
      chk("reset_commit_miso", {{(N*8-2){1'b0}}, commit_a, miso_a}, '0);

      dbuf = '{8'hA5, 8'h00, 8'h00, 8'h00};
      frame(1'b0, 8'h05, 1, 0);
      frame(1'b0, 8'h85, 2, 0);
      dbuf = '{8'h11, 8'h22, 8'h33, 8'h00};
      frame(1'b0, 8'h1E, 3, 0);
      frame(1'b0, 8'h02, 0, 4);
      frame(1'b0, 8'h07, 0, 3);
      dbuf = '{8'h5A, 8'hC3, 8'h00, 8'h00};
      frame(1'b0, 8'h7F, 2, 0);
      frame(1'b0, 8'h9F, 3, 0);

      for (int f = 0; f < 24; f++) begin
         for (int k = 0; k < 4; k++) dbuf[k] = 8'($urandom);
         frame(1'b0, 8'($urandom), int'($urandom_range(0, 4)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
      end

      dbuf = '{8'h10, 8'h20, 8'h00, 8'h00};
      frame(1'b1, 8'h03, 2, 0);
      sel = 1'b0;
      #(2*HALF);

      nss = 1'b0;
      frame_no++;
      #(2*HALF);
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h04 >> i));
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      reset_n = 1'b0;
      nss = 1'b1;
      #30;
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         live_a[i] = 8'h00;
         live_b[i] = 8'h00;
      end
      exp_a.delete();
      exp_b.delete();
      rd_q.delete();
      #(4*HALF);
      chk("after_reset_regs_a", regq_a, '0);
      chk("after_reset_regs_b", regq_b, '0);
      nss = 1'b0;
      #(4*HALF);
      nss = 1'b1;
      #(6*HALF);
      chk("nss_only_regs", regq_a, '0);
      chk("pending_commits", N*8'(exp_a.size() + exp_b.size()), '0);
      chk("pending_reads", N*8'(rd_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
